// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, one transaction in flight.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       owner_d;
  logic       sel_d;
  logic       sel_any;

  always_comb begin
    sel_d     = d_req && !(if_req && starve_cnt == LIMIT);
    sel_any   = d_req || if_req;
    state_nxt = state;
    case (state)
      IDLE:    if (sel_any) state_nxt = ISSUE;
      ISSUE:   if (mem_req && mem_ready) state_nxt = WAIT;
      WAIT:    if (mem_rvalid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      busy       <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      busy      <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (sel_any) begin
            owner_d <= sel_d;
            mem_req <= 1'b1;
            if (sel_d) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // Only a contested loss counts toward fetch starvation.
              if (if_req && starve_cnt < LIMIT) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              mem_we     <= 1'b0;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_req && mem_ready) begin
            mem_req <= 1'b0;
            if (owner_d) d_gnt  <= 1'b1;
            else         if_gnt <= 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= mem_we ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Memory-side stimulus: waits (bounded) for mem_req, accepts it, answers the cycle after acceptance.
  task automatic serve_one(input logic drop, input logic [31:0] rd,
                           output logic ok, output logic [31:0] addr, output logic we,
                           output logic gi, output logic gd, output logic vi, output logic vd);
    ok = 1'b0; addr = '0; we = 1'b0; gi = 1'b0; gd = 1'b0; vi = 1'b0; vd = 1'b0;
    for (int k = 0; k < 20 && !mem_req; k++) tick();
    if (!mem_req) return;
    ok = 1'b1; addr = mem_addr; we = mem_we;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    gi = if_gnt; gd = d_gnt;
    if (drop) begin
      if (gi) if_req = 1'b0;
      if (gd) d_req = 1'b0;
    end
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0;
    vi = if_rvalid; vd = d_rvalid;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    assert_cnt++;
    if ({mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid, busy} !== 7'b0) begin
      fail_cnt++; $display("FAIL reset_ctrl got=%b exp=0", {mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid, busy});
    end
    assert_cnt++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'b0) begin
      fail_cnt++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    tick();
    assert_cnt++;
    if ({mem_req, mem_we, busy, if_gnt} !== 4'b1010 || mem_addr !== 32'h100) begin
      fail_cnt++; $display("FAIL fetch_c1 req/we/busy/gnt=%b addr=%h exp=1010 100", {mem_req, mem_we, busy, if_gnt}, mem_addr);
    end
    tick();
    mem_ready = 1'b0;
    assert_cnt++;
    if (if_gnt !== 1'b1 || mem_req !== 1'b0 || if_rvalid !== 1'b0) begin
      fail_cnt++; $display("FAIL fetch_c2 gnt=%b req=%b rvalid=%b exp=1 0 0", if_gnt, mem_req, if_rvalid);
    end
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rvalid = 1'b0;
    assert_cnt++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || if_gnt !== 1'b0 || busy !== 1'b1) begin
      fail_cnt++; $display("FAIL fetch_c3 rvalid=%b rdata=%h gnt=%b busy=%b exp=1 deadbeef 0 1", if_rvalid, if_rdata, if_gnt, busy);
    end
    tick();
    assert_cnt++;
    if (busy !== 1'b0 || if_rvalid !== 1'b0 || if_rdata !== 32'hDEADBEEF) begin
      fail_cnt++; $display("FAIL fetch_c4 busy=%b rvalid=%b rdata=%h exp=0 0 deadbeef", busy, if_rvalid, if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    logic ok, we, gi, gd, vi, vd;
    logic [31:0] a;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    serve_one(1'b1, 32'h1111_1111, ok, a, we, gi, gd, vi, vd);
    assert_cnt++;
    if (!ok || a !== 32'h400 || {gi, gd, vi, vd} !== 4'b0101 || d_rdata !== 32'h1111_1111) begin
      fail_cnt++; $display("FAIL simul_first ok=%b addr=%h gi/gd/vi/vd=%b rdata=%h exp=1 400 0101 11111111", ok, a, {gi, gd, vi, vd}, d_rdata);
    end
    assert_cnt++;
    if (dut.starve_cnt !== 4'd1) begin
      fail_cnt++; $display("FAIL simul_starve1 got=%0d exp=1", dut.starve_cnt);
    end
    serve_one(1'b1, 32'h2222_2222, ok, a, we, gi, gd, vi, vd);
    assert_cnt++;
    if (!ok || a !== 32'h200 || {gi, gd, vi, vd} !== 4'b1010 || if_rdata !== 32'h2222_2222) begin
      fail_cnt++; $display("FAIL simul_second ok=%b addr=%h gi/gd/vi/vd=%b rdata=%h exp=1 200 1010 22222222", ok, a, {gi, gd, vi, vd}, if_rdata);
    end
    assert_cnt++;
    if (dut.starve_cnt !== 4'd0) begin
      fail_cnt++; $display("FAIL simul_starve0 got=%0d exp=0", dut.starve_cnt);
    end
  endtask

  task automatic test_starvation();
    logic ok, we, gi, gd, vi, vd;
    logic [31:0] a;
    logic exp_d;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int i = 0; i < 6; i++) begin
      exp_d = (i != 4);
      serve_one(1'b0, 32'h3000 + i, ok, a, we, gi, gd, vi, vd);
      assert_cnt++;
      if (!ok || gd !== exp_d || gi !== !exp_d || vd !== exp_d || a !== (exp_d ? 32'h500 : 32'h300)) begin
        fail_cnt++; $display("FAIL starve_arb%0d ok=%b gi=%b gd=%b vd=%b addr=%h exp_data=%b", i, ok, gi, gd, vd, a, exp_d);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();
  endtask

  task automatic test_store_backpressure();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234; mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) mem_ready = 1'b1;
      assert_cnt++;
      if ({mem_req, mem_we, d_gnt} !== 3'b110 || mem_addr !== 32'h80 || mem_wdata !== 32'h1234) begin
        fail_cnt++; $display("FAIL store_hold_c%0d req/we/gnt=%b addr=%h wdata=%h exp=110 80 1234", c, {mem_req, mem_we, d_gnt}, mem_addr, mem_wdata);
      end
    end
    tick();
    mem_ready = 1'b0;
    assert_cnt++;
    if (d_gnt !== 1'b1 || mem_req !== 1'b0) begin
      fail_cnt++; $display("FAIL store_gnt gnt=%b req=%b exp=1 0", d_gnt, mem_req);
    end
    d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    assert_cnt++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_gnt !== 1'b0) begin
      fail_cnt++; $display("FAIL store_ack rvalid=%b rdata=%h gnt=%b exp=1 0 0", d_rvalid, d_rdata, d_gnt);
    end
    d_we = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic ok, we, gi, gd, vi, vd;
    logic [31:0] a;
    if_req = 1'b1; if_addr = 32'h600; mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0; if_req = 1'b0;
    assert_cnt++;
    if (if_gnt !== 1'b1 || busy !== 1'b1) begin
      fail_cnt++; $display("FAIL rstwait_in_wait gnt=%b busy=%b exp=1 1", if_gnt, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    assert_cnt++;
    if ({mem_req, if_gnt, if_rvalid, d_rvalid, busy} !== 5'b0 || {mem_addr, if_rdata, d_rdata} !== 96'b0) begin
      fail_cnt++; $display("FAIL rstwait_cleared ctrl=%b data=%h exp=0 0", {mem_req, if_gnt, if_rvalid, d_rvalid, busy}, {mem_addr, if_rdata, d_rdata});
    end
    tick();
    mem_rvalid = 1'b0;
    assert_cnt++;
    if ({if_rvalid, d_rvalid, busy, mem_req} !== 4'b0 || if_rdata !== 32'h0) begin
      fail_cnt++; $display("FAIL rstwait_stray rv_i/rv_d/busy/req=%b rdata=%h exp=0 0", {if_rvalid, d_rvalid, busy, mem_req}, if_rdata);
    end
    if_req = 1'b1; if_addr = 32'h700;
    serve_one(1'b1, 32'h7777_0000, ok, a, we, gi, gd, vi, vd);
    assert_cnt++;
    if (!ok || a !== 32'h700 || we !== 1'b0 || {gi, gd, vi, vd} !== 4'b1010 || if_rdata !== 32'h7777_0000) begin
      fail_cnt++; $display("FAIL rstwait_next ok=%b addr=%h we=%b gi/gd/vi/vd=%b rdata=%h exp=1 700 0 1010 77770000", ok, a, we, {gi, gd, vi, vd}, if_rdata);
    end
  endtask

  task automatic test_withdrawal();
    int extra;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h900; mem_ready = 1'b0;
    tick();
    d_req = 1'b0; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    assert_cnt++;
    if (d_gnt !== 1'b1 || mem_addr !== 32'h900) begin
      fail_cnt++; $display("FAIL withdraw_gnt gnt=%b addr=%h exp=1 900", d_gnt, mem_addr);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    tick();
    mem_rvalid = 1'b0;
    assert_cnt++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h5A5A_5A5A) begin
      fail_cnt++; $display("FAIL withdraw_rvalid rvalid=%b rdata=%h exp=1 5a5a5a5a", d_rvalid, d_rdata);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_req) extra++;
    end
    assert_cnt++;
    if (extra !== 0 || busy !== 1'b0) begin
      fail_cnt++; $display("FAIL withdraw_no_reissue extra_req_cycles=%0d busy=%b exp=0 0", extra, busy);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_store_backpressure();
    test_reset_mid_wait();
    test_withdrawal();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch requester and its data (load/store) requester.
- Allows one outstanding transaction at a time.
- Data accesses have priority over fetches, with an anti-starvation counter that protects fetch.
- Sits between the pipeline datapath and the memory. Its `busy` output and the per-requester grants feed the hazard unit's stall decisions.

Parameters:
- XLEN, 32, address/data width.
- STARVE_LIMIT, 4, number of consecutive arbitration losses by fetch before fetch is forced to win (legal range 1..15).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch read request; held with if_addr until if_gnt.
- if_addr  input  XLEN  fetch address.
- if_gnt  output  1  one-cycle pulse: fetch request accepted by memory.
- if_rvalid  output  1  one-cycle pulse: if_rdata valid.
- if_rdata  output  XLEN  fetched word.
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_gnt.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  XLEN  data address.
- d_wdata  input  XLEN  store data.
- d_gnt  output  1  one-cycle pulse: data request accepted.
- d_rvalid  output  1  one-cycle pulse: load data valid, or store acknowledged.
- d_rdata  output  XLEN  load data; 0 for stores.
- mem_req  output  1  memory request valid.
- mem_we  output  1  memory write enable.
- mem_addr  output  XLEN  memory address.
- mem_wdata  output  XLEN  memory write data.
- mem_ready  input  1  memory accepts the request this cycle (mem_req && mem_ready = handshake).
- mem_rvalid  input  1  response (read data or write ack), one cycle, at or after the cycle after acceptance.
- mem_rdata  input  XLEN  memory read data.
- busy  output  1  arbiter not in IDLE.

Behaviour:
- Clocking and reset: all state updates on the clk rising edge; reset is synchronous and active-high.
- Reset: FSM goes to IDLE and starve_cnt to 0. All outputs are registered and clear to 0: mem_req, mem_we, mem_addr, mem_wdata, both gnt, both rvalid, both rdata, busy.
- Reset asserted mid-transaction abandons the transaction. A mem_rvalid arriving afterwards while in IDLE is ignored and never forwarded.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, any request: select an owner, latch owner, we, addr and wdata into the mem_* registers, set mem_req = 1, go to ISSUE. Fetch is always latched with we = 0.
- Selection rule:
  - Data wins if d_req && !(if_req && starve_cnt == STARVE_LIMIT).
  - Otherwise fetch wins if if_req.
- starve_cnt update at each selection:
  - +1 (saturating at STARVE_LIMIT) when both requested and data won.
  - Reset to 0 when fetch is selected.
  - Unchanged when only data requested.
- ISSUE: hold mem_* stable while mem_ready = 0 (any number of cycles). On mem_req && mem_ready:
  - pulse the owner's gnt in the next cycle;
  - drop mem_req;
  - go to WAIT.
- WAIT: on mem_rvalid, capture mem_rdata into the owner's rdata (d_rdata = 0 if the owner stored), set the owner's rvalid = 1, go to RESP.
- RESP: clear rvalid and return to IDLE. A new arbitration can start in the cycle after RESP.
- Minimum latency:
  - request seen in IDLE at cycle 0;
  - mem_req high in cycle 1;
  - with mem_ready = 1 in cycle 1: gnt in cycle 2;
  - with mem_rvalid in cycle 2: rvalid and rdata in cycle 3.
- Timing rules:
  - gnt and rvalid are never asserted in the same cycle.
  - rdata holds its value until the next response to the same requester.
  - busy = 1 in ISSUE, WAIT and RESP.
- Requests ignored outside IDLE: requests arriving in ISSUE/WAIT/RESP are not sampled. A requester dropping req after selection does not cancel the latched transaction; it completes normally.
- mem_rvalid in ISSUE or IDLE is a protocol error and is ignored.
- Simultaneous if_req and d_req: exactly one is granted per arbitration. The loser must keep req asserted.

Test Plan:
1. Fetch only: if_req = 1, if_addr = 0x100, mem_ready = 1, mem_rvalid the cycle after acceptance with 0xDEADBEEF -> mem_req in cycle 1 with addr 0x100 and we = 0; if_gnt in cycle 2; if_rvalid with if_rdata = 0xDEADBEEF in cycle 3; busy falls in cycle 4.
2. Simultaneous: if_req (0x200) and d_req load (0x400) both held -> data transaction first (mem_addr = 0x400), then fetch (0x200); starve_cnt goes 1 then 0.
3. Starvation, STARVE_LIMIT = 4: both requests held continuously, fetch granted only once required -> 4 data grants, then the 5th arbitration grants fetch, then data resumes.
4. Backpressure and store: store d_addr = 0x80, d_wdata = 0x1234, mem_ready low for 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata stable for 4 cycles; d_gnt one cycle after the handshake; d_rvalid with d_rdata = 0 on ack.
5. Reset mid-WAIT: reset pulsed while in WAIT, then mem_rvalid = 1 in the following cycle -> all outputs 0; no rvalid pulse; next if_req is served from IDLE normally.
6. Request withdrawal: d_req dropped one cycle after selection -> the transaction still completes with d_gnt and d_rvalid; no extra memory request is issued.
